alu_result_checker: RTL



---
 rtl/alu_result_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
// Result checker for a 32-bit, 2-bit-select ALU: it recomputes each snooped result, counts
// checks and mismatches over a programmed run length, and captures the first failure.
module alu_result_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_checks,
    input  logic               in_valid,
    input  logic [1:0]         select,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   check_count,
    output logic [CNT_W-1:0]   error_count,
    output logic               err_valid,
    output logic [1:0]         err_select,
    output logic [WIDTH-1:0]   err_a,
    output logic [WIDTH-1:0]   err_b,
    output logic [WIDTH-1:0]   err_result,
    output logic [WIDTH-1:0]   err_expected
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, accepted_q, check_count_q, error_count_q;
    logic               pass_q, err_valid_q;
    logic [1:0]         err_select_q;
    logic [WIDTH-1:0]   err_a_q, err_b_q, err_result_q, err_expected_q;

    logic               s1_valid_q;
    logic [1:0]         s1_sel_q;
    logic [WIDTH-1:0]   s1_a_q, s1_b_q, s1_res_q;

    logic               start_run;
    logic               accept;
    logic               last_accept;
    logic [WIDTH-1:0]   expected;
    logic               mismatch;

    assign start_run   = (state_q == IDLE) && start;
    assign accept      = (state_q == RUN) && in_valid && (accepted_q < target_q);
    assign last_accept = accept && ((accepted_q + CNT_W'(1)) == target_q);

    always_comb begin
        expected = '0;
        case (s1_sel_q)
            2'd0:    expected = s1_a_q + s1_b_q;
            2'd1:    expected = s1_a_q - s1_b_q;
            2'd2:    expected = s1_a_q & s1_b_q;
            default: expected = s1_a_q | s1_b_q;
        endcase
    end

    assign mismatch = s1_valid_q && (expected != s1_res_q);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = (num_checks == '0) ? DONE : RUN;
            RUN:   if (last_accept) state_d = DRAIN;
            DRAIN: if (check_count_q == target_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Stage 1 capture and run bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            accepted_q <= '0;
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_res_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (start_run) begin
                target_q   <= num_checks;
                accepted_q <= '0;
            end else if (accept) begin
                accepted_q <= accepted_q + CNT_W'(1);
                s1_sel_q   <= select;
                s1_a_q     <= A;
                s1_b_q     <= B;
                s1_res_q   <= result;
            end
        end
    end

    // Stage 2 compare, counters, first-error capture and verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_count_q  <= '0;
            error_count_q  <= '0;
            pass_q         <= 1'b0;
            err_valid_q    <= 1'b0;
            err_select_q   <= '0;
            err_a_q        <= '0;
            err_b_q        <= '0;
            err_result_q   <= '0;
            err_expected_q <= '0;
        end else if (start_run) begin
            check_count_q  <= '0;
            error_count_q  <= '0;
            pass_q         <= (num_checks == '0);
            err_valid_q    <= 1'b0;
            err_select_q   <= '0;
            err_a_q        <= '0;
            err_b_q        <= '0;
            err_result_q   <= '0;
            err_expected_q <= '0;
        end else begin
            if (s1_valid_q) check_count_q <= check_count_q + CNT_W'(1);
            if (mismatch && (error_count_q != '1)) error_count_q <= error_count_q + CNT_W'(1);
            if (mismatch && !err_valid_q) begin
                err_valid_q    <= 1'b1;
                err_select_q   <= s1_sel_q;
                err_a_q        <= s1_a_q;
                err_b_q        <= s1_b_q;
                err_result_q   <= s1_res_q;
                err_expected_q <= expected;
            end
            // Every compare has retired by the DRAIN->DONE edge, so the count is final
            if (state_q == DRAIN && state_d == DONE) pass_q <= (error_count_q == '0);
        end
    end

    assign pass         = pass_q;
    assign check_count  = check_count_q;
    assign error_count  = error_count_q;
    assign err_valid    = err_valid_q;
    assign err_select   = err_select_q;
    assign err_a        = err_a_q;
    assign err_b        = err_b_q;
    assign err_result   = err_result_q;
    assign err_expected = err_expected_q;

endmodule
